alu_acc_sequencer: RTL and testbench

//  Downstream/control stage wrapped around the 4-bit combinational ALU: owns the accumulator and flag register.

---
 rtl/alu_acc_sequencer_pkg.sv | 43 ++++
 rtl/alu_acc_sequencer_flag_reg.sv | 43 ++++
 rtl/alu_acc_sequencer.sv | 101 ++++++++++
 tb/tb_alu_acc_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_sequencer_pkg.sv
// Shared types and constants for the ALU accumulator sequencer.
// Sticky carry/overflow is selected with the ALU_ACC_STICKY_FLAGS_EN macro (see alu_acc_flag_reg).
package alu_acc_sequencer_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned OPW   = 3;
  localparam int unsigned CNTW  = 2;
  localparam int unsigned FLAGW = 4;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_NOT = 3'd5;
  localparam logic [OPW-1:0] OP_NEG = 3'd6;
  localparam logic [OPW-1:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] operand;
    logic [CNTW-1:0]  cnt;
  } cmd_t;

  // Flags reported for a direct accumulator load: only neg/zero are meaningful.
  function automatic logic [FLAGW-1:0] load_flags(input logic [WIDTH-1:0] v);
    load_flags         = '0;
    load_flags[FLAG_N] = v[WIDTH-1];
    load_flags[FLAG_Z] = (v == '0);
  endfunction

endpackage

// File: rtl/alu_acc_sequencer_flag_reg.sv
// Flag register: captures ALU flags per EXEC iteration or load-derived flags.
// With ALU_ACC_STICKY_FLAGS_EN defined, carry/overflow OR-accumulate across one command.
module alu_acc_sequencer_flag_reg
  import alu_acc_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_en,
  input  logic             exec_en,
  input  logic [FLAGW-1:0] alu_flags,
  output logic [FLAGW-1:0] flags
);

  logic [FLAGW-1:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (load_en) begin
      flags_d = load_flags(load_val);
    end else if (clr_en) begin
`ifdef ALU_ACC_STICKY_FLAGS_EN
      flags_d[FLAG_C] = 1'b0;
      flags_d[FLAG_V] = 1'b0;
`endif
    end else if (exec_en) begin
      flags_d = alu_flags;
`ifdef ALU_ACC_STICKY_FLAGS_EN
      flags_d[FLAG_C] = alu_flags[FLAG_C] | flags_q[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V] | flags_q[FLAG_V];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/alu_acc_sequencer.sv
// Control stage around the external 4-bit ALU: owns accumulator and flags, iterates count+1 times.
// Build option ALU_ACC_STICKY_FLAGS_EN selects sticky carry/overflow in the flag register.
module alu_acc_sequencer
  import alu_acc_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [CNTW-1:0]  cmd_count,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [FLAGW-1:0] alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] acc,
  output logic [FLAGW-1:0] flags
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             accept_c;

  assign accept_c = cmd_valid & cmd_ready_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cmd_d.op      = cmd_op;
          cmd_d.operand = cmd_operand;
          cmd_d.cnt     = cmd_count;
          if (cmd_load) begin
            acc_d   = cmd_operand;
            state_d = ST_RESP;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        acc_d = alu_out;
        if (cmd_q.cnt == '0) state_d = ST_RESP;
        else                 cmd_d.cnt = cmd_q.cnt - CNTW'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_q       <= acc_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  alu_acc_sequencer_flag_reg u_flag_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (accept_c & cmd_load),
    .load_val  (cmd_operand),
    .clr_en    (accept_c & ~cmd_load),
    .exec_en   (state_q == ST_EXEC),
    .alu_flags (alu_flags),
    .flags     (flags)
  );

  assign alu_in1    = acc_q;
  assign alu_in2    = cmd_q.operand;
  assign alu_opcode = cmd_q.op;
  assign acc        = acc_q;
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Randomized self-checking bench for alu_acc_sequencer with a behavioural ALU and command-level model.
module tb_alu_acc_sequencer;
  import alu_acc_sequencer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_load;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic [CNTW-1:0]  cmd_count;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic [OPW-1:0]   alu_opcode;
  logic [FLAGW-1:0] alu_flags;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] acc;
  logic [FLAGW-1:0] flags;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] m_acc;
  logic [FLAGW-1:0] m_flags;

  always #5 clk = ~clk;

  alu_acc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_count(cmd_count),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .acc(acc), .flags(flags)
  );

  // Behavioural 4-bit ALU: returns {flags(n,z,v,c), result}.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = 4'd0 - a; c = (a != 4'd0); v = (a == 4'h8); end
      default: begin r = {a[2:0], 1'b0}; c = a[3]; end
    endcase
    alu_f = {r[3], (r == 4'd0), v, c, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_f(alu_opcode, alu_in1, alu_in2);

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Command-level reference: result after count+1 applications of the op.
  task automatic model_cmd(input logic ld, input logic [2:0] op, input logic [3:0] opnd, input logic [1:0] cnt);
    logic [7:0] res;
    logic sc, sv;
    if (ld) begin
      m_acc   = opnd;
      m_flags = {opnd[3], (opnd == 4'd0), 2'b00};
    end else begin
      sc = 1'b0; sv = 1'b0;
      for (int i = 0; i <= int'(cnt); i++) begin
        res = alu_f(op, m_acc, opnd);
        m_acc = res[3:0];
        m_flags = res[7:4];
        sc |= res[4];
        sv |= res[5];
      end
`ifdef ALU_ACC_STICKY_FLAGS_EN
      m_flags[1] = sv;
      m_flags[0] = sc;
`endif
    end
  endtask

  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [3:0] opnd,
                        input logic [1:0] cnt, input int hold, input logic stall_valid);
    int lat;
    int w;
    w = 0;
    while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
    check_eq("ready_wait", 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = opnd; cmd_count = cnt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_operand = 4'($urandom); cmd_count = 2'($urandom);
    model_cmd(ld, op, opnd, cnt);
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      check_eq("busy_ready", 8'(cmd_ready), 8'd0);
      check_eq("alu_in2", 8'(alu_in2), 8'(opnd));
      check_eq("alu_op", 8'(alu_opcode), 8'(op));
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 8'(lat), ld ? 8'd0 : 8'(int'(cnt) + 1));
    check_eq("acc", 8'(acc), 8'(m_acc));
    check_eq("flags", 8'(flags), 8'(m_flags));
    check_eq("rsp_ready0", 8'(cmd_ready), 8'd0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = stall_valid;
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", 8'(rsp_valid), 8'd1);
      check_eq("hold_acc", 8'(acc), 8'(m_acc));
      check_eq("hold_flags", 8'(flags), 8'(m_flags));
      check_eq("hold_ready", 8'(cmd_ready), 8'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_done", 8'(rsp_valid), 8'd0);
    check_eq("idle_ready", 8'(cmd_ready), 8'd1);
    check_eq("idle_acc", 8'(acc), 8'(m_acc));
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_operand = '0;
    cmd_count = '0; rsp_ready = 1'b0;
    m_acc = '0; m_flags = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_ready", 8'(cmd_ready), 8'd1);
    check_eq("rst_valid", 8'(rsp_valid), 8'd0);
    check_eq("rst_acc", 8'(acc), 8'd0);
    check_eq("rst_flags", 8'(flags), 8'd0);

    do_cmd(1'b1, 3'd0, 4'h5, 2'd0, 2, 1'b0);
    check_eq("t1_flags", 8'(flags), 8'h0);
    do_cmd(1'b1, 3'd0, 4'h7, 2'd0, 0, 1'b0);
    do_cmd(1'b0, 3'd0, 4'h1, 2'd0, 0, 1'b0);
    check_eq("t2_acc", 8'(acc), 8'h8);
    check_eq("t2_flags", 8'(flags), 8'b1010);
    do_cmd(1'b1, 3'd0, 4'hF, 2'd0, 0, 1'b0);
    do_cmd(1'b0, 3'd0, 4'h1, 2'd0, 0, 1'b0);
    check_eq("t3_acc", 8'(acc), 8'h0);
    check_eq("t3_flags", 8'(flags), 8'b0101);
    do_cmd(1'b1, 3'd0, 4'h1, 2'd0, 0, 1'b0);
    do_cmd(1'b0, 3'd7, 4'h0, 2'd2, 0, 1'b0);
    check_eq("t4_acc", 8'(acc), 8'h8);
    check_eq("t4_flags", 8'(flags), 8'b1000);
    do_cmd(1'b1, 3'd0, 4'h7, 2'd0, 0, 1'b0);
    do_cmd(1'b0, 3'd0, 4'h1, 2'd1, 5, 1'b1);
    check_eq("t5_acc", 8'(acc), 8'h9);
`ifdef ALU_ACC_STICKY_FLAGS_EN
    check_eq("t5_ovf", 8'(flags[1]), 8'd1);
`else
    check_eq("t5_ovf", 8'(flags[1]), 8'd0);
`endif

    for (int n = 0; n < 80; n++) begin
      do_cmd(1'($urandom_range(0, 3) == 0), 3'($urandom), 4'($urandom), 2'($urandom),
             $urandom_range(0, 3), 1'($urandom));
    end

    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_operand = 4'h3; cmd_count = 2'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_acc", 8'(acc), 8'd0);
    check_eq("mid_rst_flags", 8'(flags), 8'd0);
    check_eq("mid_rst_valid", 8'(rsp_valid), 8'd0);
    check_eq("mid_rst_ready", 8'(cmd_ready), 8'd1);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("post_rst_valid", 8'(rsp_valid), 8'd0);
    end
    m_acc = '0; m_flags = '0;
    do_cmd(1'b0, 3'd0, 4'h2, 2'd1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
